// File: rtl/motion_seq.sv
// motion_seq: step-rate and direction sequencer for the dual stepper output stage.
// Define MOTION_RAMP_EN to build the trapezoidal accel/decel ramp; otherwise every step uses PERIOD_MIN.
module motion_seq #(
    parameter int STEPS_W      = 16,
    parameter int PER_W        = 20,
    parameter int PERIOD_START = 200000,
    parameter int PERIOD_MIN   = 50000,
    parameter int PERIOD_DELTA = 2000,
    parameter int SETTLE_CYC   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    input  logic [1:0]         cmd_op,
    input  logic [STEPS_W-1:0] cmd_steps,
    output logic               cmd_ready,
    input  logic               stop,
    output logic               speed,
    output logic               dir_left,
    output logic               dir_right,
    output logic               busy,
    output logic               done,
    output logic [1:0]         dbg_state
);
    // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready
    // and stop is low; cmd_ready is only high in IDLE, so nothing queues.

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_RUN    = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [PER_W-1:0] P_MIN       = PER_W'(PERIOD_MIN);
    localparam logic [PER_W-1:0] SETTLE_LAST = PER_W'(SETTLE_CYC - 1);
`ifdef MOTION_RAMP_EN
    localparam logic [PER_W-1:0] P_START   = PER_W'(PERIOD_START);
    localparam logic [PER_W:0]   P_DELTA_X = (PER_W+1)'(PERIOD_DELTA);
    localparam logic [PER_W-1:0] P_LOAD    = P_START;
`else
    localparam logic [PER_W-1:0] P_LOAD    = P_MIN;
`endif

    if (PERIOD_MIN < 2 || PERIOD_START < PERIOD_MIN || PERIOD_DELTA < 0 || SETTLE_CYC < 1) begin : g_bad_cfg
        $error("motion_seq: invalid period or settle configuration");
    end

    state_t             state_q;
    logic [PER_W-1:0]   per_cnt_q;
    logic [PER_W-1:0]   period_q;
    logic [PER_W-1:0]   period_d;
    logic [STEPS_W-1:0] remaining_q;
    logic [STEPS_W-1:0] remaining_d;
    logic               speed_q;
    logic               speed_d;
    logic               dir_left_q;
    logic               dir_right_q;
    logic               busy_q;
    logic               done_q;
    logic               cmd_ready_q;
    logic               step_last;
`ifdef MOTION_RAMP_EN
    logic [STEPS_W-1:0] ramp_q;
    logic [STEPS_W-1:0] ramp_d;
    logic [PER_W:0]     per_up;
    logic [PER_W:0]     per_dn;
`endif

    // Step bookkeeping: per_cnt_q is the cycle index inside the current step.
    always_comb begin
        step_last   = (per_cnt_q == period_q - PER_W'(1));
        remaining_d = remaining_q - STEPS_W'(1);
        speed_d     = (per_cnt_q + PER_W'(1)) < (period_q >> 1);
`ifdef MOTION_RAMP_EN
        per_up   = {1'b0, period_q} + P_DELTA_X;
        per_dn   = {1'b0, period_q} - P_DELTA_X;
        period_d = period_q;
        ramp_d   = ramp_q;
        // Decelerate once the steps left fit inside the steps spent accelerating.
        if (remaining_d <= ramp_q) begin
            period_d = (per_up > {1'b0, P_START}) ? P_START : per_up[PER_W-1:0];
            ramp_d   = ramp_q - STEPS_W'(1);
        end else if (period_q > P_MIN) begin
            period_d = (per_dn[PER_W] || per_dn < {1'b0, P_MIN}) ? P_MIN : per_dn[PER_W-1:0];
            ramp_d   = ramp_q + STEPS_W'(1);
        end
`else
        period_d = P_MIN;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            per_cnt_q   <= '0;
            period_q    <= P_LOAD;
            remaining_q <= '0;
            speed_q     <= 1'b0;
            dir_left_q  <= 1'b0;
            dir_right_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cmd_ready_q <= 1'b0;
`ifdef MOTION_RAMP_EN
            ramp_q      <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            if (state_q != S_IDLE && stop) begin
                state_q     <= S_IDLE;
                per_cnt_q   <= '0;
                speed_q     <= 1'b0;
                busy_q      <= 1'b0;
                cmd_ready_q <= 1'b1;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (cmd_ready_q && cmd_valid && !stop) begin
                            state_q     <= S_SETTLE;
                            per_cnt_q   <= '0;
                            period_q    <= P_LOAD;
                            remaining_q <= cmd_steps;
                            busy_q      <= 1'b1;
                            cmd_ready_q <= 1'b0;
`ifdef MOTION_RAMP_EN
                            ramp_q      <= '0;
`endif
                            // op bit 1 = turn; left wheel forward for FWD and TURN_R.
                            dir_left_q  <= (cmd_op == 2'd0) || (cmd_op == 2'd3);
                            dir_right_q <= (cmd_op == 2'd0) || (cmd_op == 2'd2);
                        end else begin
                            cmd_ready_q <= 1'b1;
                        end
                    end
                    S_SETTLE: begin
                        if (per_cnt_q == SETTLE_LAST) begin
                            per_cnt_q <= '0;
                            if (remaining_q == '0) begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= S_RUN;
                                speed_q <= 1'b1;
                            end
                        end else begin
                            per_cnt_q <= per_cnt_q + PER_W'(1);
                        end
                    end
                    S_RUN: begin
                        if (step_last) begin
                            per_cnt_q   <= '0;
                            remaining_q <= remaining_d;
                            if (remaining_d == '0) begin
                                state_q <= S_DONE;
                                speed_q <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                period_q <= period_d;
                                speed_q  <= 1'b1;
`ifdef MOTION_RAMP_EN
                                ramp_q   <= ramp_d;
`endif
                            end
                        end else begin
                            per_cnt_q <= per_cnt_q + PER_W'(1);
                            speed_q   <= speed_d;
                        end
                    end
                    S_DONE: begin
                        state_q     <= S_IDLE;
                        busy_q      <= 1'b0;
                        cmd_ready_q <= 1'b1;
                    end
                    default: begin
                        state_q     <= S_IDLE;
                        speed_q     <= 1'b0;
                        busy_q      <= 1'b0;
                        cmd_ready_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign speed     = speed_q;
    assign dir_left  = dir_left_q;
    assign dir_right = dir_right_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_motion_seq.sv
// tb_motion_seq: directed checks of motion_seq timing, direction map, stop, and reset behaviour.
module tb_motion_seq;
  localparam int STEPS_W = 16;
  localparam int PER_W   = 20;

`ifdef MOTION_RAMP_EN
  localparam int FWD6_DONE = 46;
  localparam int FWD6_HIGH = 21;
  localparam int E3        = 22;
  localparam int FWD1_DONE = 14;
  int fwd6_edges[6] = '{4, 14, 22, 28, 32, 38};
`else
  localparam int FWD6_DONE = 28;
  localparam int FWD6_HIGH = 12;
  localparam int E3        = 12;
  localparam int FWD1_DONE = 8;
  int fwd6_edges[6] = '{4, 8, 12, 16, 20, 24};
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'd0;
  logic [STEPS_W-1:0] cmd_steps = '0;
  logic stop = 1'b0;
  logic cmd_ready, speed, dir_left, dir_right, busy, done;
  logic [1:0] dbg_state;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];
  int edge_q[$];
  int done_at, done_cnt, ready_at, high_cnt;
  logic prev_speed;

  motion_seq #(
    .STEPS_W(STEPS_W), .PER_W(PER_W), .PERIOD_START(10), .PERIOD_MIN(4),
    .PERIOD_DELTA(2), .SETTLE_CYC(3)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_steps(cmd_steps),
    .cmd_ready(cmd_ready), .stop(stop), .speed(speed), .dir_left(dir_left),
    .dir_right(dir_right), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic step_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // driver
  task automatic send(input logic [1:0] op, input logic [STEPS_W-1:0] steps);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_steps = steps;
    step_cycle();
    cmd_valid = 1'b0;
  endtask

  task automatic clear_watch();
    edge_q.delete();
    exp_q.delete();
    done_at = -1;
    done_cnt = 0;
    ready_at = -1;
    high_cnt = 0;
    prev_speed = speed;
  endtask

  // Samples n cycles starting at offset start_off from the accept cycle.
  task automatic watch(input int start_off, input int n);
    int off;
    for (int i = 0; i < n; i++) begin
      off = start_off + i;
      if (speed === 1'b1 && prev_speed !== 1'b1) edge_q.push_back(off);
      if (speed === 1'b1) high_cnt++;
      if (done === 1'b1) begin
        done_cnt++;
        done_at = off;
      end
      if (cmd_ready === 1'b1 && ready_at < 0) ready_at = off;
      prev_speed = speed;
      step_cycle();
    end
  endtask

  // scoreboard
  task automatic check_edges(input string tag);
    check({tag, "_n_edges"}, edge_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < edge_q.size(); i++)
      check($sformatf("%s_edge%0d", tag, i), edge_q[i], exp_q[i]);
  endtask

  initial begin
    repeat (3) step_cycle();
    check("rst_speed", speed, 0);
    check("rst_dir_l", dir_left, 0);
    check("rst_dir_r", dir_right, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready", cmd_ready, 0);
    check("rst_state", dbg_state, 0);
    rst = 1'b0;
    step_cycle();
    check("ready_after_rst", cmd_ready, 1);

    // FWD 6 steps
    clear_watch();
    send(2'd0, 16'd6);
    check("fwd6_dir_l", dir_left, 1);
    check("fwd6_dir_r", dir_right, 1);
    check("fwd6_busy", busy, 1);
    check("fwd6_ready", cmd_ready, 0);
    check("fwd6_state", dbg_state, 1);
    watch(1, 50);
    for (int i = 0; i < 6; i++) exp_q.push_back(fwd6_edges[i]);
    check_edges("fwd6");
    check("fwd6_done_at", done_at, FWD6_DONE);
    check("fwd6_done_cnt", done_cnt, 1);
    check("fwd6_ready_at", ready_at, FWD6_DONE + 1);
    check("fwd6_high_cnt", high_cnt, FWD6_HIGH);
    check("fwd6_hold_l", dir_left, 1);
    check("fwd6_hold_r", dir_right, 1);
    check("fwd6_idle_busy", busy, 0);

    // TURN_L 0 steps
    clear_watch();
    send(2'd2, 16'd0);
    check("tl0_dir_l", dir_left, 0);
    check("tl0_dir_r", dir_right, 1);
    watch(1, 8);
    check_edges("tl0");
    check("tl0_done_at", done_at, 4);
    check("tl0_ready_at", ready_at, 5);

    // BACK 100 steps, stop after third edge
    clear_watch();
    send(2'd1, 16'd100);
    check("back_dir_l", dir_left, 0);
    check("back_dir_r", dir_right, 0);
    watch(1, E3 - 1);
    check("back_edges_before", edge_q.size(), 2);
    check("back_third_edge", speed, 1);
    stop = 1'b1;
    step_cycle();
    stop = 1'b0;
    check("stop_speed", speed, 0);
    check("stop_busy", busy, 0);
    check("stop_ready", cmd_ready, 1);
    check("stop_done", done, 0);
    check("stop_dir_l", dir_left, 0);
    check("stop_dir_r", dir_right, 0);
    clear_watch();
    watch(E3 + 1, 30);
    check("stop_no_done", done_cnt, 0);
    check("stop_no_edges", edge_q.size(), 0);

    // stop with a command in IDLE drops the command; stop alone is ignored
    stop = 1'b1;
    cmd_valid = 1'b1;
    cmd_op = 2'd0;
    cmd_steps = 16'd3;
    step_cycle();
    stop = 1'b0;
    cmd_valid = 1'b0;
    check("drop_busy", busy, 0);
    check("drop_ready", cmd_ready, 1);
    check("drop_dir_l", dir_left, 0);
    check("drop_state", dbg_state, 0);
    stop = 1'b1;
    step_cycle();
    stop = 1'b0;
    check("idle_stop_ready", cmd_ready, 1);

    // cmd_valid during RUN is ignored
    clear_watch();
    send(2'd0, 16'd6);
    watch(1, 9);
    cmd_valid = 1'b1;
    cmd_op = 2'd3;
    cmd_steps = 16'd2;
    watch(10, 1);
    cmd_valid = 1'b0;
    check("ign_dir_l", dir_left, 1);
    check("ign_dir_r", dir_right, 1);
    check("ign_busy", busy, 1);
    watch(11, 39);
    for (int i = 0; i < 6; i++) exp_q.push_back(fwd6_edges[i]);
    check_edges("ign");
    check("ign_done_at", done_at, FWD6_DONE);
    check("ign_done_cnt", done_cnt, 1);

    // reset mid-step of TURN_R, then FWD 1
    clear_watch();
    send(2'd3, 16'd5);
    check("tr_dir_l", dir_left, 1);
    check("tr_dir_r", dir_right, 0);
    watch(1, 4);
    check("tr_midstep", speed, 1);
    rst = 1'b1;
    step_cycle();
    rst = 1'b0;
    check("mrst_speed", speed, 0);
    check("mrst_dir_l", dir_left, 0);
    check("mrst_dir_r", dir_right, 0);
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    check("mrst_ready", cmd_ready, 0);
    step_cycle();
    check("mrst_ready_after", cmd_ready, 1);
    clear_watch();
    send(2'd0, 16'd1);
    check("fwd1_dir_l", dir_left, 1);
    check("fwd1_dir_r", dir_right, 1);
    check("fwd1_busy", busy, 1);
    watch(1, 16);
    exp_q.push_back(4);
    check_edges("fwd1");
    check("fwd1_done_at", done_at, FWD1_DONE);
    check("fwd1_done_cnt", done_cnt, 1);
    check("fwd1_ready_at", ready_at, FWD1_DONE + 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
